// File: rtl/msi_l1_cache_ctrl.sv
// msi_l1_cache_ctrl: fully-associative MSI L1 controller with upgrade, dirty writeback and snoop servicing.
module msi_l1_cache_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4,
  parameter int NUM_LINES = 2,
  parameter int IDX_W = 1
) (
  input  logic              Clock_i,
  input  logic              Reset_i,
  input  logic              ProcValid_i,
  input  logic [1:0]        WriteOrRead_i,
  input  logic [ADDR_W-1:0] ProcAddress_i,
  input  logic [DATA_W-1:0] ProcData_i,
  output logic              ProcReady_o,
  output logic [1:0]        HitOrMiss_o,
  output logic              ProcDone_o,
  output logic [DATA_W-1:0] ProcRdData_o,
  output logic [1:0]        Signal_o,
  output logic              DirValid_o,
  output logic [ADDR_W-1:0] DirAddress_o,
  output logic [DATA_W-1:0] DirData_o,
  output logic [1:0]        WriteBack_o,
  input  logic              DirAck_i,
  input  logic [DATA_W-1:0] MemData_i,
  input  logic              SnoopValid_i,
  input  logic [1:0]        SnoopCmd_i,
  input  logic [ADDR_W-1:0] SnoopAddress_i,
  output logic              SnoopReady_o,
  output logic              SnoopReply_o,
  output logic [DATA_W-1:0] SnoopData_o
);
  localparam logic [2:0] ST_E = 3'b000, ST_I = 3'b001, ST_S = 3'b010, ST_M = 3'b011;
  typedef enum logic [2:0] {IDLE, SNOOP, WB, REQ, DONE} state_t;
  state_t state_q;
  logic [2:0] st_q [NUM_LINES];
  logic [ADDR_W-1:0] ad_q [NUM_LINES];
  logic [DATA_W-1:0] dt_q [NUM_LINES];
  logic [IDX_W-1:0] ptr_q, vic_q, hidx, iidx, fidx, sidx, vic;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wd_q;
  logic wr_q, up_q, hit, imat, fr, sh, wr;
  assign wr = ~WriteOrRead_i[0];
  assign ProcReady_o = (state_q == IDLE) && !SnoopValid_i;
  assign SnoopReady_o = (state_q == IDLE);
  // descending scan so the lowest-index candidate wins
  always_comb begin
    hit = 1'b0; hidx = '0; imat = 1'b0; iidx = '0; fr = 1'b0; fidx = '0; sh = 1'b0; sidx = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (ad_q[i] == ProcAddress_i && (st_q[i] == ST_S || st_q[i] == ST_M)) begin hit = 1'b1; hidx = IDX_W'(i); end
      if (ad_q[i] == ProcAddress_i && st_q[i] == ST_I) begin imat = 1'b1; iidx = IDX_W'(i); end
      if (st_q[i] == ST_E || st_q[i] == ST_I) begin fr = 1'b1; fidx = IDX_W'(i); end
      if (ad_q[i] == SnoopAddress_i && (st_q[i] == ST_S || st_q[i] == ST_M)) begin sh = 1'b1; sidx = IDX_W'(i); end
    end
    vic = imat ? iidx : fr ? fidx : ptr_q;
  end
  always_ff @(posedge Clock_i) begin
    if (Reset_i) begin
      state_q <= IDLE; ptr_q <= '0; vic_q <= '0; addr_q <= '0; wd_q <= '0; wr_q <= 1'b0; up_q <= 1'b0;
      HitOrMiss_o <= '0; ProcDone_o <= 1'b0; ProcRdData_o <= '0; Signal_o <= '0; DirValid_o <= 1'b0;
      DirAddress_o <= '0; DirData_o <= '0; WriteBack_o <= '0; SnoopReply_o <= 1'b0; SnoopData_o <= '0;
      for (int i = 0; i < NUM_LINES; i++) begin st_q[i] <= ST_E; ad_q[i] <= '0; dt_q[i] <= '0; end
    end else begin
      ProcDone_o <= 1'b0;
      SnoopReply_o <= 1'b0;
      case (state_q)
        IDLE: begin
          DirValid_o <= 1'b0; Signal_o <= '0; WriteBack_o <= '0; DirAddress_o <= '0; DirData_o <= '0;
          HitOrMiss_o <= '0; ProcRdData_o <= '0; SnoopData_o <= '0;
          if (SnoopValid_i) begin
            state_q <= SNOOP;
            SnoopReply_o <= 1'b1;
            if (sh && st_q[sidx] == ST_M && SnoopCmd_i != 2'b00) begin
              SnoopData_o <= dt_q[sidx]; WriteBack_o <= 2'b01;
              st_q[sidx] <= (SnoopCmd_i == 2'b01) ? ST_S : ST_I;
            end else if (sh && SnoopCmd_i[1]) st_q[sidx] <= ST_I;
          end else if (ProcValid_i && !WriteOrRead_i[1]) begin
            wr_q <= wr; addr_q <= ProcAddress_i; wd_q <= ProcData_i;
            if (hit && (!wr || st_q[hidx] == ST_M)) begin
              state_q <= DONE; ProcDone_o <= 1'b1; HitOrMiss_o <= 2'b01;
              ProcRdData_o <= wr ? '0 : dt_q[hidx];
              if (wr) dt_q[hidx] <= ProcData_i;
            end else if (hit) begin
              state_q <= REQ; up_q <= 1'b1; vic_q <= hidx;
              DirValid_o <= 1'b1; Signal_o <= 2'b11; DirAddress_o <= ProcAddress_i;
            end else begin
              up_q <= 1'b0; vic_q <= vic;
              if (!imat && !fr) ptr_q <= (ptr_q == IDX_W'(NUM_LINES - 1)) ? '0 : ptr_q + 1'b1;
              DirValid_o <= 1'b1;
              if (st_q[vic] == ST_M) begin
                state_q <= WB; WriteBack_o <= 2'b01; DirAddress_o <= ad_q[vic]; DirData_o <= dt_q[vic];
              end else begin
                state_q <= REQ; Signal_o <= wr ? 2'b10 : 2'b01; DirAddress_o <= ProcAddress_i;
              end
            end
          end
        end
        SNOOP: begin
          state_q <= IDLE; WriteBack_o <= '0; SnoopData_o <= '0;
        end
        WB: begin
          state_q <= REQ; WriteBack_o <= '0; DirData_o <= '0;
          Signal_o <= wr_q ? 2'b10 : 2'b01; DirAddress_o <= addr_q;
        end
        REQ: if (DirAck_i) begin
          state_q <= DONE; DirValid_o <= 1'b0; Signal_o <= '0; DirAddress_o <= '0;
          ProcDone_o <= 1'b1; HitOrMiss_o <= up_q ? 2'b01 : 2'b00; ProcRdData_o <= wr_q ? '0 : MemData_i;
          st_q[vic_q] <= wr_q ? ST_M : ST_S; ad_q[vic_q] <= addr_q; dt_q[vic_q] <= wr_q ? wd_q : MemData_i;
        end
        DONE: begin
          state_q <= IDLE; HitOrMiss_o <= '0; ProcRdData_o <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_msi_l1_cache_ctrl.sv
// tb_msi_l1_cache_ctrl: directed vector table plus hand sequences for snoops, arbitration and reset abort.
module tb_msi_l1_cache_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic ProcValid = 1'b0, DirAck = 1'b0, SnoopValid = 1'b0;
  logic [1:0] WriteOrRead = 2'b01, SnoopCmd = 2'b00;
  logic [3:0] ProcAddress = '0, ProcData = '0, MemData = '0, SnoopAddress = '0;
  logic ProcReady, ProcDone, DirValid, SnoopReady, SnoopReply;
  logic [1:0] HitOrMiss, Signal, WriteBack;
  logic [3:0] ProcRdData, DirAddress, DirData, SnoopData;
  int n_vec = 0, n_bad = 0;

  msi_l1_cache_ctrl #(.ADDR_W(4), .DATA_W(4), .NUM_LINES(2), .IDX_W(1)) dut (
    .Clock_i(clk), .Reset_i(rst), .ProcValid_i(ProcValid), .WriteOrRead_i(WriteOrRead),
    .ProcAddress_i(ProcAddress), .ProcData_i(ProcData), .ProcReady_o(ProcReady),
    .HitOrMiss_o(HitOrMiss), .ProcDone_o(ProcDone), .ProcRdData_o(ProcRdData),
    .Signal_o(Signal), .DirValid_o(DirValid), .DirAddress_o(DirAddress), .DirData_o(DirData),
    .WriteBack_o(WriteBack), .DirAck_i(DirAck), .MemData_i(MemData), .SnoopValid_i(SnoopValid),
    .SnoopCmd_i(SnoopCmd), .SnoopAddress_i(SnoopAddress), .SnoopReady_o(SnoopReady),
    .SnoopReply_o(SnoopReply), .SnoopData_o(SnoopData));

  always #5 clk = ~clk;

  typedef struct packed {
    logic wr; logic [3:0] addr, wd, md; logic [1:0] sig, hit; logic [3:0] rd;
    logic wb; logic [3:0] wba, wbd;
  } vec_t;
  vec_t v [13];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // sig==00 marks a hit served without the directory
  task automatic txn(input vec_t t);
    @(negedge clk);
    chk("proc_ready", ProcReady, 1);
    ProcValid = 1'b1; WriteOrRead = {1'b0, ~t.wr}; ProcAddress = t.addr; ProcData = t.wd;
    @(negedge clk);
    ProcValid = 1'b0;
    if (t.sig == 2'b00) chk("hit_no_dir", DirValid, 0);
    else begin
      if (t.wb) begin
        chk("wb_valid", DirValid, 1); chk("wb_flag", WriteBack, 2'b01); chk("wb_sig", Signal, 0);
        chk("wb_addr", DirAddress, t.wba); chk("wb_data", DirData, t.wbd);
        @(negedge clk);
      end
      for (int k = 0; k < 2; k++) begin
        chk("req_valid", DirValid, 1); chk("req_sig", Signal, t.sig);
        chk("req_addr", DirAddress, t.addr); chk("req_wbflag", WriteBack, 0); chk("req_early_done", ProcDone, 0);
        if (k == 1) begin DirAck = 1'b1; MemData = t.md; end
        @(negedge clk);
      end
      DirAck = 1'b0;
      chk("done_dirv", DirValid, 0);
    end
    chk("done", ProcDone, 1); chk("hitmiss", HitOrMiss, t.hit); chk("rddata", ProcRdData, t.rd);
    @(negedge clk);
    chk("done_pulse", ProcDone, 0);
  endtask

  task automatic snoop(input logic [1:0] cmd, input logic [3:0] a, input logic [3:0] d, input logic [1:0] wb);
    @(negedge clk);
    chk("snoop_ready", SnoopReady, 1);
    SnoopValid = 1'b1; SnoopCmd = cmd; SnoopAddress = a;
    @(negedge clk);
    SnoopValid = 1'b0;
    chk("snoop_reply", SnoopReply, 1); chk("snoop_data", SnoopData, d);
    chk("snoop_wb", WriteBack, wb); chk("snoop_dirv", DirValid, 0);
    @(negedge clk);
    chk("snoop_pulse", SnoopReply, 0);
  endtask

  function automatic vec_t mk(input logic w, input logic [3:0] a, input logic [3:0] wd, input logic [3:0] md,
                              input logic [1:0] sig, input logic [1:0] hit, input logic [3:0] rd,
                              input logic wb, input logic [3:0] wba, input logic [3:0] wbd);
    mk = '{w, a, wd, md, sig, hit, rd, wb, wba, wbd};
  endfunction

  initial begin
    v[0]  = mk(0, 4'h1, 4'h0, 4'h2, 2'b01, 2'b00, 4'h2, 0, 4'h0, 4'h0);
    v[1]  = mk(0, 4'h1, 4'h0, 4'h0, 2'b00, 2'b01, 4'h2, 0, 4'h0, 4'h0);
    v[2]  = mk(1, 4'h1, 4'h6, 4'h0, 2'b11, 2'b01, 4'h0, 0, 4'h0, 4'h0);
    v[3]  = mk(0, 4'h1, 4'h0, 4'h0, 2'b00, 2'b01, 4'h6, 0, 4'h0, 4'h0);
    v[4]  = mk(1, 4'h1, 4'h2, 4'h0, 2'b00, 2'b01, 4'h0, 0, 4'h0, 4'h0);
    v[5]  = mk(0, 4'h1, 4'h0, 4'h0, 2'b00, 2'b01, 4'h2, 0, 4'h0, 4'h0);
    v[6]  = mk(1, 4'h3, 4'h4, 4'h0, 2'b10, 2'b00, 4'h0, 0, 4'h0, 4'h0);
    v[7]  = mk(0, 4'h3, 4'h0, 4'h0, 2'b00, 2'b01, 4'h4, 0, 4'h0, 4'h0);
    v[8]  = mk(0, 4'h5, 4'h0, 4'h9, 2'b01, 2'b00, 4'h9, 1, 4'h1, 4'h2);
    v[9]  = mk(0, 4'h7, 4'h0, 4'hA, 2'b01, 2'b00, 4'hA, 1, 4'h3, 4'h4);
    v[10] = mk(0, 4'h5, 4'h0, 4'h0, 2'b00, 2'b01, 4'h9, 0, 4'h0, 4'h0);
    v[11] = mk(1, 4'h8, 4'hF, 4'h0, 2'b10, 2'b00, 4'h0, 0, 4'h0, 4'h0);
    v[12] = mk(0, 4'h8, 4'h0, 4'h0, 2'b00, 2'b01, 4'hF, 0, 4'h0, 4'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", ProcReady, 1); chk("rst_sready", SnoopReady, 1); chk("rst_done", ProcDone, 0);
    chk("rst_dirv", DirValid, 0); chk("rst_sig", Signal, 0); chk("rst_wb", WriteBack, 0);
    chk("rst_reply", SnoopReply, 0); chk("rst_hm", HitOrMiss, 0);
    for (int i = 0; i < 13; i++) txn(v[i]);
    // unsupported command code is never accepted
    @(negedge clk);
    ProcValid = 1'b1; WriteOrRead = 2'b10; ProcAddress = 4'h8;
    @(negedge clk);
    ProcValid = 1'b0; WriteOrRead = 2'b01;
    chk("bad_cmd_done", ProcDone, 0); chk("bad_cmd_dirv", DirValid, 0); chk("bad_cmd_ready", ProcReady, 1);
    snoop(2'b01, 4'h8, 4'hF, 2'b01);
    txn(mk(0, 4'h8, 4'h0, 4'h0, 2'b00, 2'b01, 4'hF, 0, 4'h0, 4'h0));
    snoop(2'b10, 4'h8, 4'h0, 2'b00);
    txn(mk(0, 4'h8, 4'h0, 4'h3, 2'b01, 2'b00, 4'h3, 0, 4'h0, 4'h0));
    txn(mk(0, 4'h7, 4'h0, 4'h0, 2'b00, 2'b01, 4'hA, 0, 4'h0, 4'h0));
    txn(mk(1, 4'h7, 4'h5, 4'h0, 2'b11, 2'b01, 4'h0, 0, 4'h0, 4'h0));
    snoop(2'b11, 4'h7, 4'h5, 2'b01);
    txn(mk(0, 4'h7, 4'h0, 4'h6, 2'b01, 2'b00, 4'h6, 0, 4'h0, 4'h0));
    snoop(2'b01, 4'hE, 4'h0, 2'b00);
    // snoop and request together: snoop first, request held until IDLE returns
    @(negedge clk);
    SnoopValid = 1'b1; SnoopCmd = 2'b01; SnoopAddress = 4'h8;
    ProcValid = 1'b1; WriteOrRead = 2'b01; ProcAddress = 4'h8;
    #1 chk("arb_ready_low", ProcReady, 0);
    @(negedge clk);
    SnoopValid = 1'b0;
    chk("arb_reply", SnoopReply, 1); chk("arb_no_done", ProcDone, 0); chk("arb_busy", ProcReady, 0);
    @(negedge clk);
    chk("arb_ready_back", ProcReady, 1);
    @(negedge clk);
    ProcValid = 1'b0;
    chk("arb_done", ProcDone, 1); chk("arb_hit", HitOrMiss, 2'b01); chk("arb_rd", ProcRdData, 4'h3);
    // reset while waiting for DirAck
    @(negedge clk);
    @(negedge clk);
    ProcValid = 1'b1; ProcAddress = 4'hC;
    @(negedge clk);
    ProcValid = 1'b0;
    chk("abort_req", DirValid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_dirv", DirValid, 0); chk("abort_done", ProcDone, 0);
    @(negedge clk);
    chk("abort_ready", ProcReady, 1); chk("abort_done2", ProcDone, 0); chk("abort_dirv2", DirValid, 0);
    txn(mk(0, 4'h8, 4'h0, 4'h1, 2'b01, 2'b00, 4'h1, 0, 4'h0, 4'h0));
    txn(mk(0, 4'h7, 4'h0, 4'h2, 2'b01, 2'b00, 4'h2, 0, 4'h0, 4'h0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  always @(negedge clk) if (DirValid && SnoopReply) begin
    n_vec++; n_bad++;
    $display("FAIL dir_snoop_overlap: got both high required exclusive");
  end
endmodule

// File: doc/msi_l1_cache_ctrl.md
Name: msi_l1_cache_ctrl

Overview:
- Parametrised, per-processor L1 cache controller for the MSI directory protocol.
- Generalises the fixed two-line, read-miss-only processor model to NUM_LINES fully-associative lines, with complete read/write hit and miss handling, S->M upgrade, dirty-victim writeback, and directory snoop (fetch/invalidate) servicing.
- Sits between one test-driven processor port and the directory/memory interface.

Parameters:
- ADDR_W, 4, address/tag width.
- DATA_W, 4, data word width (one word per line).
- NUM_LINES, 2, number of fully-associative lines (>=2).
- IDX_W, 1, ceil(log2(NUM_LINES)), victim pointer width.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- ProcValid  in  1  processor request valid.
- WriteOrRead  in  2  2'b00 write, 2'b01 read; other codes are ignored (request not accepted).
- ProcAddress  in  ADDR_W  request address.
- ProcData  in  DATA_W  write data.
- ProcReady  out  1  high in IDLE when no snoop is pending; request accepted when ProcValid&&ProcReady.
- HitOrMiss  out  2  2'b01 hit, 2'b00 miss; valid with ProcDone.
- ProcDone  out  1  one-cycle completion pulse.
- ProcRdData  out  DATA_W  read result, valid with ProcDone.
- Signal  out  2  directory command: 00 empty, 01 ReadMiss, 10 WriteMiss, 11 Invalidate (upgrade).
- DirValid  out  1  command/writeback valid.
- DirAddress  out  ADDR_W  command/writeback address.
- DirData  out  DATA_W  writeback data.
- WriteBack  out  2  2'b01 when DirData carries dirty data, else 2'b00.
- DirAck  in  1  directory accepts the command; for a miss, also marks MemData valid.
- MemData  in  DATA_W  fill data.
- SnoopValid  in  1  directory-forwarded request.
- SnoopCmd  in  2  01 Fetch (M->S), 10 Invalidate, 11 FetchInvalidate.
- SnoopAddress  in  ADDR_W  snooped address.
- SnoopReady  out  1  high in IDLE.
- SnoopReply  out  1  one-cycle acknowledge.
- SnoopData  out  DATA_W  line data returned on a snoop of an M line.

Behaviour:
- Line state encoding is 3-bit: empty 000, I 001, S 010, M 011.
- Reset: all lines empty with addr/data 0; FSM to IDLE; victim pointer 0; all outputs 0, except ProcReady and SnoopReady, which are 1 in the cycle after reset deasserts.
- Reset mid-operation aborts any in-flight request. No DirValid in the following cycle. The aborted request never gets a ProcDone.
- Lookup: a hit requires an address match on a line in S or M. An I/empty match or no match is a miss. At most one line matches.
- FSM states: IDLE, SNOOP, WB, REQ, DONE.
- IDLE priority: a snoop (SnoopValid) wins over a processor request in the same cycle. The request must be re-presented later.
- Read hit, or write hit on M:
  - The cycle after acceptance: ProcDone=1, HitOrMiss=01.
  - Write: data is updated and the line stays M.
  - Read: ProcRdData carries the line data.
- Write hit on S: go to REQ with Signal=11. Once DirAck is seen, write the data, set the line to M, and pulse ProcDone with HitOrMiss=01 the next cycle.
- Miss victim selection:
  - Use the matching I line if one exists.
  - Otherwise use the lowest-index empty/I line.
  - Otherwise use the line at the round-robin pointer, which then increments modulo NUM_LINES.
- Victim in M: WB state for exactly one cycle with DirValid=1, WriteBack=01, Signal=00, and the victim's address and data. Then go to REQ.
- REQ:
  - Hold DirValid=1, Signal=01 (read) or 10 (write), and DirAddress=ProcAddress until DirAck. Outputs stay stable while waiting.
  - On DirAck, fill the line: address, MemData (read) or ProcData (write), state S (read) or M (write).
  - Then go to DONE: ProcDone=1, HitOrMiss=00, and ProcRdData=MemData on a read. Return to IDLE.
- Miss latency with a clean victim: Signal is asserted 1 cycle after acceptance, and ProcDone comes 1 cycle after DirAck. A dirty victim adds 1 cycle.
- SNOOP (1 cycle): SnoopReply=1.
  - Fetch on an M line: SnoopData=data, WriteBack=01, line becomes S.
  - Invalidate on an S line: line becomes I, WriteBack=00.
  - Invalidate or FetchInvalidate on an M line: data is returned with WriteBack=01 and the line becomes I.
  - Snoop miss, or Fetch on an S line: reply only, WriteBack=00, no state change.
- Snoops arriving outside IDLE are not accepted (SnoopReady=0). The directory holds them.
- DirValid and SnoopReply are never both high in the same cycle.

Test Plan:
- Reset, then read addr 4'b0001 -> ReadMiss (Signal=01, DirAddress=0001); DirAck with MemData=4'b0010 -> ProcDone, HitOrMiss=00, ProcRdData=0010; line is S.
- Re-read 0001 -> ProcDone the next cycle, HitOrMiss=01, no DirValid; write 4'b0110 to 0001 -> Signal=11 until DirAck, then line is M with data 0110.
- With NUM_LINES=2, both lines M (0001/0010, 0011/0100), read 0101 -> WB cycle carrying 0001/0010 with WriteBack=01, then ReadMiss 0101; the pointer advances to 1.
- Line 0001 in M with data 0110, SnoopCmd=01 -> SnoopReply, SnoopData=0110, WriteBack=01, line becomes S; then SnoopCmd=10 -> line becomes I, WriteBack=00; a following read of 0001 misses.
- SnoopValid and ProcValid in the same IDLE cycle -> snoop is served first and ProcReady=0 that cycle; the request completes afterwards.
- Reset asserted while in REQ with DirAck withheld -> DirValid=0 the next cycle, no ProcDone, all lines empty.
